regfile_mp_sb: RTL and testbench
================================

# regfile_mp_sb

Parametrised multi-port integer register file with an integrated write-back scoreboard, used by the pipeline's ID stage. The read-port count, write-port count, data width and register count are set by parameters. Same-cycle write-to-read bypass is optional. Per-register busy bits are set when an instruction with a destination issues and cleared when that destination writes back. This block is the register-file and hazard-tracking point for single- and dual-issue pipeline variants.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- NRD, 2, number of read ports
- NWR, 1, number of write ports (1..4)
- BYPASS, 1, 1 = forward same-cycle write data and busy-clear to readers
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and is never busy
- AW (localparam) = $clog2(NREGS)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
- rd_busy  out  NRD  1 = the register addressed on port k has an outstanding write
- wr_en  in  NWR  write enable per write port
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- iss_valid  in  1  an instruction with destination iss_rd issues this cycle
- iss_rd  in  AW  destination of the issuing instruction
- flush  in  1  synchronous clear of all busy bits; register contents are kept
- busy_vec  out  NREGS  raw scoreboard state, for debug and the stall unit

## Operation
- Storage is NREGS x XLEN. On each rising edge, every write port j with wr_en[j]=1 commits wr_data[j] to entry wr_addr[j].
- Address collision between write ports: the highest-indexed port wins the data.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 and rd_busy=0.
  - Issues to address 0 are ignored.
- Reads are combinational:
  - rd_data[k] = the stored entry, except when BYPASS=1 and some wr_en[j]=1 with wr_addr[j]=rd_addr[k].
  - In that case rd_data[k] = wr_data of the highest such j.
  - With BYPASS=0, the old value is read and the new value is visible from the next cycle.
- Scoreboard: busy[r] is a registered bit.
  - Set on a clock edge when iss_valid=1 and iss_rd=r.
  - Cleared on a clock edge when any wr_en[j]=1 with wr_addr[j]=r.
  - Set and clear of the same r in the same cycle: the set wins, because a new producer supersedes the old one.
  - flush=1 clears every bit and overrides an iss_valid in the same cycle.
- rd_busy[k]:
  - BYPASS=1: busy[rd_addr[k]] AND NOT (any write this cycle to rd_addr[k]).
  - BYPASS=0: busy[rd_addr[k]] only.
  - An issue in the current cycle is not visible until the next cycle.
- busy_vec equals the stored busy bits. Bit 0 is forced to 0 when ZERO_REG=1.
- There is no single-writer check. Multiple outstanding issues to the same r behave as one busy bit, cleared by the first write-back.

## Timing
- Reset (asynchronous, any cycle, including mid-operation):
  - All entries become 0 and all busy bits become 0 immediately.
  - rd_data then reads 0, rd_busy=0 and busy_vec=0 combinationally.
- Write latency: one edge to storage. Read-after-write in the same cycle costs 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- Issue-to-busy latency: 1 edge. Write-back-to-not-busy: 0 cycles with BYPASS=1, 1 edge with BYPASS=0.
- The only comb paths are rd_addr/wr_*/storage/busy -> rd_data and rd_busy. No comb path exists from iss_* to any output.

## Structure
- Package regfile_pkg holds:
  - the default XLEN and NREGS constants;
  - function clog2-safe AW;
  - function addr_slice / data_slice helpers for the flattened buses.
- Sub-module regfile_scoreboard holds the busy bits, the set/clear/flush priority and the rd_busy generation. The top level holds storage, write arbitration and bypass muxes.

## Test plan
- Reset released, then read every address on both ports -> rd_data=0 and busy_vec=0; assert rst mid-stream after writes -> everything reads 0 in the same cycle.
- Write x5=0xDEADBEEF with BYPASS=1 while rd_addr0=5 in the same cycle -> rd_data0=0xDEADBEEF that cycle. Repeat with BYPASS=0 -> old value that cycle, 0xDEADBEEF the next.
- Write x0=0x1234 and issue to x0 -> rd_data=0, rd_busy=0 and busy_vec[0]=0.
- NWR=2, both ports write x7 with 0x11 (port 0) and 0x22 (port 1) -> x7 reads 0x22 afterwards; the same-cycle bypass also returns 0x22.
- Issue x3 -> busy_vec[3]=1 after 1 edge. Then in one cycle write back x3 and issue x3 again -> busy stays 1. A later write-back clears it; with BYPASS=1, rd_busy reads 0 in the write-back cycle.
- Issue x4, x9 and x12, then flush together with iss_valid for x6 -> busy_vec=0 next cycle and register contents are unchanged.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and bus-slicing helpers for the multi-port register file
// and its write-back scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int clog2_safe(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Bit offset of lane k within a flattened address bus.
  function automatic int addr_slice(input int k, input int aw);
    return k * aw;
  endfunction

  // Bit offset of lane k within a flattened data bus.
  function automatic int data_slice(input int k, input int xlen);
    return k * xlen;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy bits: issue sets, write-back clears, flush wipes all,
// plus the per-read-port busy indication seen by the ID stage.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2_safe(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_rd_i,
  input  logic              flush_i,
  output logic [NRD-1:0]    rd_busy_o,
  output logic [NREGS-1:0]  busy_vec_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW-1:0]    wa_s;
  logic [AW-1:0]    ra_s;
  logic             b_s;

  // Priority low to high: write-back clear, issue set, flush, zero register.
  always_comb begin
    busy_d = busy_q;
    wa_s   = '0;
    for (int j = 0; j < NWR; j++) begin
      wa_s         = wr_addr_i[addr_slice(j, AW) +: AW];
      busy_d[wa_s] = wr_en_i[j] ? 1'b0 : busy_d[wa_s];
    end
    busy_d[iss_rd_i] = iss_valid_i ? 1'b1 : busy_d[iss_rd_i];
    busy_d           = flush_i ? '0 : busy_d;
    busy_d[0]        = (ZERO_REG != 0) ? 1'b0 : busy_d[0];
  end

  // Busy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Raw state export with the hardwired-zero register masked.
  always_comb begin
    busy_vec_o    = busy_q;
    busy_vec_o[0] = (ZERO_REG != 0) ? 1'b0 : busy_q[0];
  end

  // A write-back landing this cycle already satisfies the reader when bypassing.
  always_comb begin
    rd_busy_o = '0;
    ra_s      = '0;
    b_s       = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra_s = rd_addr_i[addr_slice(k, AW) +: AW];
      b_s  = busy_vec_o[ra_s];
      for (int j = 0; j < NWR; j++) begin
        b_s = ((BYPASS != 0) && wr_en_i[j] &&
               (wr_addr_i[addr_slice(j, AW) +: AW] == ra_s)) ? 1'b0 : b_s;
      end
      rd_busy_o[k] = b_s;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with optional same-cycle bypass and an
// integrated write-back scoreboard for the ID stage.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2_safe(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  input  logic                flush_i,
  output logic [NREGS-1:0]    busy_vec_o
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [AW-1:0]   wa_s;
  logic            we_s;
  logic [AW-1:0]   ra_s;
  logic [XLEN-1:0] rv_s;
  logic            hit_s;

  // Later write ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    mem_d = mem_q;
    wa_s  = '0;
    we_s  = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      wa_s        = wr_addr_i[addr_slice(j, AW) +: AW];
      we_s        = wr_en_i[j] && !((ZERO_REG != 0) && (wa_s == '0));
      mem_d[wa_s] = we_s ? wr_data_i[data_slice(j, XLEN) +: XLEN] : mem_d[wa_s];
    end
  end

  // Register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Combinational read ports with optional forwarding of this cycle's writes.
  always_comb begin
    rd_data_o = '0;
    ra_s      = '0;
    rv_s      = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra_s = rd_addr_i[addr_slice(k, AW) +: AW];
      rv_s = mem_q[ra_s];
      for (int j = 0; j < NWR; j++) begin
        hit_s = (BYPASS != 0) && wr_en_i[j] &&
                (wr_addr_i[addr_slice(j, AW) +: AW] == ra_s);
        rv_s  = hit_s ? wr_data_i[data_slice(j, XLEN) +: XLEN] : rv_s;
      end
      rv_s = ((ZERO_REG != 0) && (ra_s == '0)) ? '0 : rv_s;
      rd_data_o[data_slice(k, XLEN) +: XLEN] = rv_s;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_i   (rd_addr_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .flush_i     (flush_i),
    .rd_busy_o   (rd_busy_o),
    .busy_vec_o  (busy_vec_o)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: a dual-write bypassing instance and a single-write
// non-bypassing instance, checked against an expected-value queue.
module tb_regfile_mp_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dual-write, bypassing instance
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0]        rd_busy;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              flush;
  logic [NREGS-1:0]  busy_vec;

  // single-write, non-bypassing instance
  logic [2*AW-1:0]   nb_rd_addr;
  logic [2*XLEN-1:0] nb_rd_data;
  logic [1:0]        nb_rd_busy;
  logic [0:0]        nb_wr_en;
  logic [AW-1:0]     nb_wr_addr;
  logic [XLEN-1:0]   nb_wr_data;
  logic              nb_iss_valid;
  logic [AW-1:0]     nb_iss_rd;
  logic              nb_flush;
  logic [NREGS-1:0]  nb_busy_vec;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .iss_valid_i(iss_valid),
    .iss_rd_i(iss_rd), .flush_i(flush), .busy_vec_o(busy_vec)
  );

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)) u_nb (
    .clk(clk), .rst(rst), .rd_addr_i(nb_rd_addr), .rd_data_o(nb_rd_data), .rd_busy_o(nb_rd_busy),
    .wr_en_i(nb_wr_en), .wr_addr_i(nb_wr_addr), .wr_data_i(nb_wr_data), .iss_valid_i(nb_iss_valid),
    .iss_rd_i(nb_iss_rd), .flush_i(nb_flush), .busy_vec_o(nb_busy_vec)
  );

  logic [31:0] exp_q [$];
  logic [31:0] mem_m [NREGS];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    nb_rd_addr = '0; nb_wr_en = '0; nb_wr_addr = '0; nb_wr_data = '0;
    nb_iss_valid = 1'b0; nb_iss_rd = '0; nb_flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [31:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = a;
    wr_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    for (int a = 0; a < NREGS; a++) begin
      next_cycle();
      rd_addr = {5'(NREGS - 1 - a), 5'(a)};
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (rd_data[31:0] !== e) begin n_miss++; $display("FAIL reset_rd0 a=%0d got %h want %h", a, rd_data[31:0], e); end
      e = exp_q.pop_front(); n_vec++;
      if (rd_data[63:32] !== e) begin n_miss++; $display("FAIL reset_rd1 a=%0d got %h want %h", a, rd_data[63:32], e); end
      e = exp_q.pop_front(); n_vec++;
      if (busy_vec !== e) begin n_miss++; $display("FAIL reset_busy_vec got %h want %h", busy_vec, e); end
    end
  endtask

  task automatic test_random_rw();
    logic [31:0] e;
    logic [31:0] v;
    logic [AW-1:0] ra;
    for (int i = 0; i < NREGS; i++) mem_m[i] = 32'h0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      wr_en   = 2'($urandom_range(0, 3));
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {$urandom(), $urandom()};
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      for (int k = 0; k < 2; k++) begin
        ra = rd_addr[k*AW +: AW];
        v  = mem_m[ra];
        for (int j = 0; j < 2; j++)
          if (wr_en[j] && wr_addr[j*AW +: AW] == ra) v = wr_data[j*XLEN +: XLEN];
        if (ra == 5'd0) v = 32'h0;
        exp_q.push_back(v);
      end
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != 5'd0) mem_m[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (rd_data[31:0] !== e) begin n_miss++; $display("FAIL rand_rd0 c=%0d got %h want %h", c, rd_data[31:0], e); end
      e = exp_q.pop_front(); n_vec++;
      if (rd_data[63:32] !== e) begin n_miss++; $display("FAIL rand_rd1 c=%0d got %h want %h", c, rd_data[63:32], e); end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    next_cycle();
    set_wr(0, 5'd5, 32'hDEADBEEF); rd_addr[4:0] = 5'd5;
    nb_wr_en = 1'b1; nb_wr_addr = 5'd5; nb_wr_data = 32'hCAFE0001;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd_data[31:0] !== e) begin n_miss++; $display("FAIL bypass_same_cycle got %h want %h", rd_data[31:0], e); end
    next_cycle();
    nb_wr_en = 1'b1; nb_wr_addr = 5'd5; nb_wr_data = 32'hDEADBEEF; nb_rd_addr[4:0] = 5'd5;
    exp_q.push_back(32'hCAFE0001);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (nb_rd_data[31:0] !== e) begin n_miss++; $display("FAIL nobypass_old got %h want %h", nb_rd_data[31:0], e); end
    next_cycle();
    nb_rd_addr[4:0] = 5'd5;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (nb_rd_data[31:0] !== e) begin n_miss++; $display("FAIL nobypass_next got %h want %h", nb_rd_data[31:0], e); end
  endtask

  task automatic test_nb_busy();
    logic [31:0] e;
    next_cycle();
    nb_iss_valid = 1'b1; nb_iss_rd = 5'd8;
    next_cycle();
    nb_wr_en = 1'b1; nb_wr_addr = 5'd8; nb_wr_data = 32'h88; nb_rd_addr[4:0] = 5'd8;
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, nb_rd_busy[0]} !== e) begin n_miss++; $display("FAIL nb_busy_wb_cycle got %h want %h", nb_rd_busy[0], e); end
    e = exp_q.pop_front(); n_vec++;
    if (nb_rd_data[31:0] !== e) begin n_miss++; $display("FAIL nb_data_wb_cycle got %h want %h", nb_rd_data[31:0], e); end
    next_cycle();
    nb_rd_addr[4:0] = 5'd8;
    exp_q.push_back(32'h0); exp_q.push_back(32'h88);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, nb_rd_busy[0]} !== e) begin n_miss++; $display("FAIL nb_busy_after got %h want %h", nb_rd_busy[0], e); end
    e = exp_q.pop_front(); n_vec++;
    if (nb_rd_data[31:0] !== e) begin n_miss++; $display("FAIL nb_data_after got %h want %h", nb_rd_data[31:0], e); end
  endtask

  task automatic test_zero_reg();
    logic [31:0] e;
    next_cycle();
    set_wr(0, 5'd0, 32'h1234); iss_valid = 1'b1; iss_rd = 5'd0; rd_addr = {5'd0, 5'd0};
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd_data[31:0] !== e) begin n_miss++; $display("FAIL zero_bypass got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rd_busy[0]} !== e) begin n_miss++; $display("FAIL zero_rd_busy_now got %h want %h", rd_busy[0], e); end
    next_cycle();
    rd_addr = {5'd0, 5'd0};
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd_data[31:0] !== e) begin n_miss++; $display("FAIL zero_rd got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rd_busy[0]} !== e) begin n_miss++; $display("FAIL zero_rd_busy got %h want %h", rd_busy[0], e); end
    e = exp_q.pop_front(); n_vec++;
    if (busy_vec !== e) begin n_miss++; $display("FAIL zero_busy_vec got %h want %h", busy_vec, e); end
  endtask

  task automatic test_collision();
    logic [31:0] e;
    next_cycle();
    set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22); rd_addr = {5'd7, 5'd0};
    exp_q.push_back(32'h22);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd_data[63:32] !== e) begin n_miss++; $display("FAIL collide_bypass got %h want %h", rd_data[63:32], e); end
    next_cycle();
    rd_addr = {5'd7, 5'd7};
    exp_q.push_back(32'h22); exp_q.push_back(32'h22);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (rd_data[31:0] !== e) begin n_miss++; $display("FAIL collide_rd0 got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); n_vec++;
    if (rd_data[63:32] !== e) begin n_miss++; $display("FAIL collide_rd1 got %h want %h", rd_data[63:32], e); end
  endtask

  task automatic test_busy();
    logic [31:0] e;
    // cycle-by-cycle expectations for {busy_vec, rd_busy[0]} with rd_addr0 = 3
    logic [31:0] exp_bv [6];
    logic        exp_rb [6];
    exp_bv = '{32'h0, 32'h8, 32'h8, 32'h8, 32'h8, 32'h0};
    exp_rb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      rd_addr[4:0] = 5'd3;
      if (c == 0 || c == 2) begin iss_valid = 1'b1; iss_rd = 5'd3; end
      if (c == 2 || c == 4) set_wr(0, 5'd3, 32'h33);
      exp_q.push_back(exp_bv[c]); exp_q.push_back({31'd0, exp_rb[c]});
      @(negedge clk);
      e = exp_q.pop_front(); n_vec++;
      if (busy_vec !== e) begin n_miss++; $display("FAIL busy_vec c=%0d got %h want %h", c, busy_vec, e); end
      e = exp_q.pop_front(); n_vec++;
      if ({31'd0, rd_busy[0]} !== e) begin n_miss++; $display("FAIL rd_busy c=%0d got %h want %h", c, rd_busy[0], e); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] e;
    next_cycle();
    set_wr(0, 5'd4, 32'hA4); set_wr(1, 5'd6, 32'hA6); iss_valid = 1'b1; iss_rd = 5'd4;
    next_cycle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    next_cycle();
    iss_valid = 1'b1; iss_rd = 5'd12;
    next_cycle();
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6;
    exp_q.push_back(32'h0000_1210);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (busy_vec !== e) begin n_miss++; $display("FAIL flush_pre got %h want %h", busy_vec, e); end
    next_cycle();
    rd_addr = {5'd6, 5'd4};
    exp_q.push_back(32'h0); exp_q.push_back(32'hA4); exp_q.push_back(32'hA6);
    @(negedge clk);
    e = exp_q.pop_front(); n_vec++;
    if (busy_vec !== e) begin n_miss++; $display("FAIL flush_busy_vec got %h want %h", busy_vec, e); end
    e = exp_q.pop_front(); n_vec++;
    if (rd_data[31:0] !== e) begin n_miss++; $display("FAIL flush_keep_x4 got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); n_vec++;
    if (rd_data[63:32] !== e) begin n_miss++; $display("FAIL flush_keep_x6 got %h want %h", rd_data[63:32], e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    next_cycle();
    iss_valid = 1'b1; iss_rd = 5'd10;
    next_cycle();
    rd_addr = {5'd10, 5'd5}; nb_rd_addr[4:0] = 5'd5;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h1); exp_q.push_back(32'hDEADBEEF);
    #2;
    e = exp_q.pop_front(); n_vec++;
    if (rd_data[31:0] !== e) begin n_miss++; $display("FAIL mid_pre_rd0 got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); n_vec++;
    if ({31'd0, rd_busy[1]} !== e) begin n_miss++; $display("FAIL mid_pre_busy1 got %h want %h", rd_busy[1], e); end
    e = exp_q.pop_front(); n_vec++;
    if (nb_rd_data[31:0] !== e) begin n_miss++; $display("FAIL mid_pre_nb got %h want %h", nb_rd_data[31:0], e); end
    rst = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (rd_data[31:0] !== e) begin n_miss++; $display("FAIL mid_rd0 got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); n_vec++;
    if ({30'd0, rd_busy} !== e) begin n_miss++; $display("FAIL mid_rd_busy got %h want %h", rd_busy, e); end
    e = exp_q.pop_front(); n_vec++;
    if (busy_vec !== e) begin n_miss++; $display("FAIL mid_busy_vec got %h want %h", busy_vec, e); end
    e = exp_q.pop_front(); n_vec++;
    if (nb_rd_data[31:0] !== e) begin n_miss++; $display("FAIL mid_nb got %h want %h", nb_rd_data[31:0], e); end
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    rst = 1'b0;
    test_reset();
    test_random_rw();
    test_bypass();
    test_nb_busy();
    test_zero_reg();
    test_collision();
    test_busy();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
